// File: rtl/uart_capture_pkg.sv
// uart_capture_pkg: shared types and helpers for the uart_capture_rx receiver.
//   state_e        - receiver FSM states (PARITY is only reached when
//                    UART_CAPTURE_PARITY_EN is defined)
//   LINE_END_BYTE  - byte value that raises line_done_o when pushed
//   calc_div/half  - clocks per bit and clocks to the middle of the start bit
package uart_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_e;

  localparam logic [7:0] LINE_END_BYTE = 8'h0A;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int calc_half(input int clk_hz, input int baud);
    return calc_div(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_capture_fifo.sv
// uart_capture_fifo: synchronous first-word-fall-through byte FIFO.
//   clk, rst       - clock, synchronous active-high reset (flushes the FIFO)
//   push_i/data_i  - write request and byte; ignored when full unless popping
//   pop_i          - consumer takes the head byte (ignored when empty)
//   data_o         - registered head byte; holds the last value when empty
//   full_o/empty_o - occupancy flags
//   count_o        - occupancy, 0..DEPTH
module uart_capture_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_capture_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic          wr_en, rd_en;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign data_o  = head_q;
  assign count_o = count_q;

  always_comb begin
    rd_en    = pop_i && !empty_o;
    // A full FIFO still accepts a write when a pop frees a slot this cycle.
    wr_en    = push_i && (!full_o || rd_en);
    rd_next  = rd_ptr_q + 1'b1;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_next : rd_ptr_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Head register: next entry on pop, bypass the write when the slot
    // behind the head is being written in this very cycle.
    head_d = head_q;
    if (rd_en) begin
      if (count_q > ONE_CNT) head_d = mem_q[rd_next];
      else if (wr_en)        head_d = data_i;
    end else if (empty_o && wr_en) begin
      head_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/uart_capture_rx.sv
// uart_capture_rx: 8N1 UART receiver feeding a FWFT byte FIFO.
//   clk, rst        - clock, synchronous active-high reset
//   rx_i, rx_en_i   - serial line (idle high), receiver enable
//   data_o, valid_o, ready_i - FIFO head with valid/ready handshake
//   line_done_o     - pulse in the cycle 0x0A is pushed
//   frame_err_o     - pulse on a low stop bit
//   parity_err_o    - pulse on even-parity mismatch (UART_CAPTURE_PARITY_EN)
//   overflow_o      - sticky, a byte was dropped on a full FIFO
//   fifo_count_o    - FIFO occupancy
// Define UART_CAPTURE_PARITY_EN to add a parity bit between data and stop.
module uart_capture_rx
  import uart_capture_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD_RATE   = 3125000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  input  logic                          rx_en_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          line_done_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int DIV   = calc_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int HALF  = calc_half(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  if (DIV < 4) begin : g_div_check
    $error("uart_capture_rx: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
  end

  state_e           state_q, state_d;
  logic             sync1_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_q, push_d;
  logic             line_done_q, line_done_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  logic             par_bad;
  logic             cnt_done;
  logic             fifo_full, fifo_empty;

`ifdef UART_CAPTURE_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
  assign par_bad      = par_bad_q;
  assign parity_err_o = parity_err_q;
`else
  assign par_bad      = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  assign cnt_done = (cnt_q == DIV_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    line_done_d = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_CAPTURE_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        // Re-check the line mid start bit to reject short low glitches.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_done) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_CAPTURE_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_CAPTURE_PARITY_EN
      ST_PARITY: begin
        if (cnt_done) begin
          cnt_d        = '0;
          par_bad_d    = ^{shift_q, rx_s_q};
          parity_err_d = par_bad_d;
          state_d      = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push_d      = !par_bad;
            line_done_d = !par_bad && (shift_q == LINE_END_BYTE);
            state_d     = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        // Stay here until the line returns high so a held-low line
        // cannot be mistaken for a stream of 0x00 frames.
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rx_en_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end

    overflow_d = overflow_q | (push_q & fifo_full & ~(ready_i & ~fifo_empty));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      line_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef UART_CAPTURE_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= rx_i;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      line_done_q <= line_done_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
`ifdef UART_CAPTURE_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // shift_q is stable during the push cycle (FSM is back in IDLE).
  uart_capture_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .data_i  (shift_q),
    .pop_i   (ready_i),
    .data_o  (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign valid_o     = ~fifo_empty;
  assign line_done_o = line_done_q;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_capture_rx.sv
// Testbench for uart_capture_rx: directed scenarios plus a randomized frame
// stream checked against a byte-queue reference model.
module tb_uart_capture_rx;

  localparam int CLK_HZ = 25000000;
  localparam int BAUD   = 3125000;
  localparam int DEPTH  = 16;
  localparam int DIV    = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       rst, rx_i, rx_en_i, ready_i;
  logic [7:0] data_o;
  logic       valid_o, line_done_o, frame_err_o, parity_err_o, overflow_o;
  logic [$clog2(DEPTH):0] fifo_count_o;

  uart_capture_rx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx_i),
    .rx_en_i      (rx_en_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .line_done_o  (line_done_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .overflow_o   (overflow_o),
    .fifo_count_o (fifo_count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_line = 0, n_ferr = 0, n_perr = 0;
  int exp_line = 0, exp_ferr = 0, exp_perr = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Pulse counters and transfer capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (line_done_o)  n_line++;
    if (frame_err_o)  n_ferr++;
    if (parity_err_o) n_perr++;
    if (valid_o && ready_i) got_q.push_back(data_o);
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    tick(DIV);
  endtask

  // Start bit, data LSB first, then the parity bit when that build option is on.
  task automatic send_head(input logic [7:0] b, input logic par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_CAPTURE_PARITY_EN
    drive_bit((^b) ^ !par_ok);
`endif
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
    send_head(b, par_ok);
    drive_bit(stop_ok);
    if (!stop_ok) drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  // Frame during which the receiver is disabled after four data bits.
  task automatic send_drop(input logic [7:0] b);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx_en_i = 1'b0;
    for (int i = 4; i < 8; i++) drive_bit(b[i]);
`ifdef UART_CAPTURE_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rx_en_i = 1'b1;
  endtask

  task automatic drain(input string tag);
    int guard;
    ready_i = 1'b1;
    guard = 0;
    tick(1);
    while (valid_o && guard < 200) begin
      tick(1);
      guard++;
    end
    ready_i = 1'b0;
    tick(1);
    check({tag, "_timeout"}, 32'(guard < 200), 32'd1);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
    $display("drain %s: %0d bytes", tag, got_q.size());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int guard;
    int lines_before;
    rst = 1'b1; rx_i = 1'b1; rx_en_i = 1'b1; ready_i = 1'b0;
    tick(4);
    check("rst_data", data_o, 8'h00);
    check("rst_valid", valid_o, 1'b0);
    check("rst_count", fifo_count_o, 0);
    check("rst_overflow", overflow_o, 1'b0);
    check("rst_line_done", line_done_o, 1'b0);
    check("rst_frame_err", frame_err_o, 1'b0);
    check("rst_parity_err", parity_err_o, 1'b0);
    rst = 1'b0;
    tick(2 * DIV);

    // Single clean byte.
    send_frame(8'h55, 1'b1, 1'b1);
    $display("frame 0x55 sent");
    check("b55_valid", valid_o, 1'b1);
    check("b55_data", data_o, 8'h55);
    check("b55_count", fifo_count_o, 1);
    check("b55_ferr", n_ferr, 0);
    check("b55_perr", n_perr, 0);
    exp_q.push_back(8'h55);
    drain("b55");

    // Three-cycle low glitch on an idle line.
    rx_i = 1'b0; tick(3); rx_i = 1'b1; tick(4 * DIV);
    $display("glitch sent");
    check("glitch_valid", valid_o, 1'b0);
    check("glitch_count", fifo_count_o, 0);
    check("glitch_ferr", n_ferr, 0);

    // Bad stop bit followed by a held-low line, then a good byte.
    send_head(8'hA3, 1'b1);
    rx_i = 1'b0;
    tick(DIV + 40);
    rx_i = 1'b1;
    tick(2 * DIV);
    exp_ferr++;
    send_frame(8'h41, 1'b1, 1'b1);
    $display("break frame 0xA3 then 0x41 sent");
    check("break_ferr", n_ferr, exp_ferr);
    exp_q.push_back(8'h41);
    drain("break");

    // Overflow: 17 bytes with the consumer stalled.
    for (int b = 0; b < 17; b++) begin
      send_frame(8'(b), 1'b1, 1'b1);
      $display("frame 0x%02h sent (stalled)", b);
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(8'(b));
        if (8'(b) == 8'h0A) exp_line++;
      end
      if (b == 15) begin
        check("ovf_full_count", fifo_count_o, DEPTH);
        check("ovf_not_yet", overflow_o, 1'b0);
      end
    end
    check("ovf_count", fifo_count_o, DEPTH);
    check("ovf_flag", overflow_o, 1'b1);
    drain("ovf");
    check("ovf_sticky", overflow_o, 1'b1);
    check("ovf_hold_last", data_o, 8'h0F);
    check("ovf_line", n_line, exp_line);

    // Reset mid-frame with a byte already queued.
    send_frame(8'h33, 1'b1, 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    rx_i = 1'b1;
    rst = 1'b1;
    tick(3);
    check("mrst_data", data_o, 8'h00);
    check("mrst_valid", valid_o, 1'b0);
    check("mrst_count", fifo_count_o, 0);
    check("mrst_overflow", overflow_o, 1'b0);
    check("mrst_pulses", {29'd0, line_done_o, frame_err_o, parity_err_o}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    tick(2 * DIV);

    // Line end byte: line_done_o coincides with the write, valid_o follows.
    lines_before = n_line;
    send_head(8'h0A, 1'b1);
    rx_i = 1'b1;
    guard = 0;
    while (!line_done_o && guard < 3 * DIV) begin
      tick(1);
      guard++;
    end
    check("nl_seen", line_done_o, 1'b1);
    check("nl_valid_same", valid_o, 1'b0);
    tick(1);
    check("nl_valid_next", valid_o, 1'b1);
    check("nl_data", data_o, 8'h0A);
    check("nl_single", line_done_o, 1'b0);
    tick(2 * DIV);
    check("nl_pulses", n_line - lines_before, 1);
    $display("frame 0x0a sent after reset");
    exp_line++;
    exp_q.push_back(8'h0A);
    drain("nl");

`ifdef UART_CAPTURE_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    exp_perr++;
    check("par_bad_perr", n_perr, exp_perr);
    check("par_bad_valid", valid_o, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_good_perr", n_perr, exp_perr);
    exp_q.push_back(8'h07);
    drain("par");
`endif

    // Randomized stream; every eighth frame the consumer is forced ready so
    // the FIFO never accumulates enough bytes to overflow.
    for (int f = 0; f < 40; f++) begin
      logic [7:0] b;
      logic stop_ok, par_ok;
      int kind;
      b       = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
      stop_ok = ($urandom_range(0, 7) != 0);
`ifdef UART_CAPTURE_PARITY_EN
      par_ok  = ($urandom_range(0, 7) != 0);
`else
      par_ok  = 1'b1;
`endif
      ready_i = (f % 8 == 7) ? 1'b1 : ($urandom_range(0, 3) != 0);
      kind    = $urandom_range(0, 9);
      if (kind == 0) begin
        send_drop(b);
      end else if (kind == 1) begin
        rx_i = 1'b0; tick($urandom_range(1, 3)); rx_i = 1'b1; tick(2 * DIV);
      end else begin
        send_frame(b, stop_ok, par_ok);
        if (!par_ok)  exp_perr++;
        if (!stop_ok) exp_ferr++;
        if (stop_ok && par_ok) begin
          exp_q.push_back(b);
          if (b == 8'h0A) exp_line++;
        end
      end
      $display("frame %0d: kind=%0d byte=0x%02h stop_ok=%0d par_ok=%0d ready=%0d",
               f, kind, b, stop_ok, par_ok, ready_i);
    end
    drain("rand");
    check("rand_overflow", overflow_o, 1'b0);
    check("rand_count", fifo_count_o, 0);
    check("total_line", n_line, exp_line);
    check("total_ferr", n_ferr, exp_ferr);
    check("total_perr", n_perr, exp_perr);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
